// File: rtl/xbox_mem_pkg.sv
// Shared types and the byte-enable merge helper for the XBOX memory responder.
package xbox_mem_pkg;

  localparam int XBOX_WORDS = 8;

  typedef logic [XBOX_WORDS-1:0][31:0] xbox_line_t;
  typedef logic [31:0]                 xbox_be_t;

  // be bit b selects byte b%4 of word b/4
  function automatic xbox_line_t xbox_apply_be(input xbox_line_t old_line,
                                               input xbox_line_t new_line,
                                               input xbox_be_t   be);
    xbox_line_t r;
    r = old_line;
    for (int w = 0; w < XBOX_WORDS; w++)
      for (int b = 0; b < 4; b++)
        if (be[w*4+b]) r[w][b*8 +: 8] = new_line[w][b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/xbox_mem_bank.sv
// One line-organised SRAM instance: xlr/host write mux and registered xlr read.
// XBOX_MEM_RDW_BYPASS_EN: a same-cycle xlr rd+wr returns the merged line instead of old data.
module xbox_mem_bank import xbox_mem_pkg::*; #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] xlr_addr,
  input  xbox_line_t    xlr_wdata,
  input  xbox_be_t      xlr_be,
  input  logic          xlr_rd,
  input  logic          xlr_wr,
  output xbox_line_t    xlr_rdata,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  xbox_line_t    host_wdata,
  input  xbox_be_t      host_be,
  output xbox_line_t    host_rline
);

  xbox_line_t mem [2**AW];
  xbox_line_t xlr_old, xlr_new, rd_line;

  assign xlr_old    = mem[xlr_addr];
  assign xlr_new    = xbox_apply_be(xlr_old, xlr_wdata, xlr_be);
  assign host_rline = mem[host_addr];

`ifdef XBOX_MEM_RDW_BYPASS_EN
  assign rd_line = xlr_wr ? xlr_new : xlr_old;
`else
  assign rd_line = xlr_old;
`endif

  // Storage is never cleared; the top only enables host_we when xlr is idle here.
  always_ff @(posedge clk) begin
    if (xlr_wr)       mem[xlr_addr]  <= xlr_new;
    else if (host_we) mem[host_addr] <= xbox_apply_be(mem[host_addr], host_wdata, host_be);
  end

  always_ff @(posedge clk) begin
    if (rst)         xlr_rdata <= '0;
    else if (xlr_rd) xlr_rdata <= rd_line;
  end

endmodule

// File: rtl/xbox_mem_responder.sv
// XBOX accelerator memory responder: NUM_MEMS banks, accelerator-priority host port.
// Optional XBOX_MEM_RDW_BYPASS_EN (in xbox_mem_bank) merges same-cycle xlr rd+wr data.
module xbox_mem_responder import xbox_mem_pkg::*; #(
  parameter int NUM_MEMS           = 1,
  parameter int LOG2_LINES_PER_MEM = 4,
  parameter int HOST_SEL_W         = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]   xlr_mem_addr,
  input  xbox_line_t [NUM_MEMS-1:0]                     xlr_mem_wdata,
  input  xbox_be_t   [NUM_MEMS-1:0]                     xlr_mem_be,
  input  logic [NUM_MEMS-1:0]                           xlr_mem_rd,
  input  logic [NUM_MEMS-1:0]                           xlr_mem_wr,
  output xbox_line_t [NUM_MEMS-1:0]                     xlr_mem_rdata,
  input  logic                                          host_mem_req,
  input  logic                                          host_mem_wr,
  input  logic [HOST_SEL_W-1:0]                         host_mem_sel,
  input  logic [LOG2_LINES_PER_MEM-1:0]                 host_mem_addr,
  input  xbox_line_t                                    host_mem_wdata,
  input  xbox_be_t                                      host_mem_be,
  output logic                                          host_mem_gnt,
  output xbox_line_t                                    host_mem_rdata,
  output logic                                          host_mem_rvalid,
  output logic                                          host_mem_err,
  output logic [15:0]                                   host_stall_cnt
);

  logic                       sel_ok, sel_busy, host_rd_go, host_err_go;
  logic [NUM_MEMS-1:0]        host_we;
  xbox_line_t [NUM_MEMS-1:0]  host_rline;
  xbox_line_t                 host_rline_sel;

  // Out-of-range sel leaves sel_ok low, so it is granted at once and reads as zero.
  always_comb begin
    sel_ok         = 1'b0;
    sel_busy       = 1'b0;
    host_rline_sel = '0;
    for (int i = 0; i < NUM_MEMS; i++) begin
      if (host_mem_sel == HOST_SEL_W'(i)) begin
        sel_ok         = 1'b1;
        sel_busy       = xlr_mem_rd[i] | xlr_mem_wr[i];
        host_rline_sel = host_rline[i];
      end
    end
  end

  assign host_mem_gnt = host_mem_req & ~(sel_ok & sel_busy);
  assign host_rd_go   = host_mem_gnt & ~host_mem_wr;
  assign host_err_go  = host_mem_gnt & ~sel_ok;

  always_comb begin
    host_we = '0;
    for (int i = 0; i < NUM_MEMS; i++)
      host_we[i] = host_mem_gnt & host_mem_wr & (host_mem_sel == HOST_SEL_W'(i));
  end

  for (genvar g = 0; g < NUM_MEMS; g++) begin : g_bank
    xbox_mem_bank #(.AW(LOG2_LINES_PER_MEM)) u_bank (
      .clk        (clk),
      .rst        (rst),
      .xlr_addr   (xlr_mem_addr[g]),
      .xlr_wdata  (xlr_mem_wdata[g]),
      .xlr_be     (xlr_mem_be[g]),
      .xlr_rd     (xlr_mem_rd[g]),
      .xlr_wr     (xlr_mem_wr[g]),
      .xlr_rdata  (xlr_mem_rdata[g]),
      .host_we    (host_we[g]),
      .host_addr  (host_mem_addr),
      .host_wdata (host_mem_wdata),
      .host_be    (host_mem_be),
      .host_rline (host_rline[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      host_mem_rdata  <= '0;
      host_mem_rvalid <= 1'b0;
      host_mem_err    <= 1'b0;
      host_stall_cnt  <= '0;
    end else begin
      host_mem_rvalid <= host_rd_go;
      host_mem_err    <= host_err_go;
      if (host_rd_go) host_mem_rdata <= host_rline_sel;
      if (host_mem_req && !host_mem_gnt && host_stall_cnt != 16'hFFFF)
        host_stall_cnt <= host_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_xbox_mem_responder.sv
// Randomised + directed bench for xbox_mem_responder against a line-level memory model.
module tb_xbox_mem_responder;
  import xbox_mem_pkg::*;

  localparam int NM = 2;
  localparam int AW = 4;
  localparam int SW = 2;
  localparam int LINES = 1 << AW;
`ifdef XBOX_MEM_RDW_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0][AW-1:0] xlr_mem_addr;
  xbox_line_t [NM-1:0]   xlr_mem_wdata;
  xbox_be_t   [NM-1:0]   xlr_mem_be;
  logic [NM-1:0]         xlr_mem_rd, xlr_mem_wr;
  xbox_line_t [NM-1:0]   xlr_mem_rdata;
  logic                  host_mem_req, host_mem_wr;
  logic [SW-1:0]         host_mem_sel;
  logic [AW-1:0]         host_mem_addr;
  xbox_line_t            host_mem_wdata;
  xbox_be_t              host_mem_be;
  logic                  host_mem_gnt;
  xbox_line_t            host_mem_rdata;
  logic                  host_mem_rvalid, host_mem_err;
  logic [15:0]           host_stall_cnt;

  xbox_mem_responder #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(AW), .HOST_SEL_W(SW)) dut (
    .clk(clk), .rst(rst),
    .xlr_mem_addr(xlr_mem_addr), .xlr_mem_wdata(xlr_mem_wdata), .xlr_mem_be(xlr_mem_be),
    .xlr_mem_rd(xlr_mem_rd), .xlr_mem_wr(xlr_mem_wr), .xlr_mem_rdata(xlr_mem_rdata),
    .host_mem_req(host_mem_req), .host_mem_wr(host_mem_wr), .host_mem_sel(host_mem_sel),
    .host_mem_addr(host_mem_addr), .host_mem_wdata(host_mem_wdata), .host_mem_be(host_mem_be),
    .host_mem_gnt(host_mem_gnt), .host_mem_rdata(host_mem_rdata),
    .host_mem_rvalid(host_mem_rvalid), .host_mem_err(host_mem_err),
    .host_stall_cnt(host_stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [255:0] m_mem [NM][LINES];
  logic [255:0] m_xrd [NM];
  logic [255:0] m_hrd;
  logic         m_rv, m_err, exp_gnt, obs_gnt;
  logic [15:0]  m_stall;

  function automatic logic [255:0] merge(input logic [255:0] o, input logic [255:0] n,
                                         input logic [31:0] be);
    logic [255:0] m;
    for (int k = 0; k < 256; k++) m[k] = be[k/8];
    return (o & ~m) | (n & m);
  endfunction

  task automatic idle();
    rst = 1'b0;
    xlr_mem_addr = '0; xlr_mem_wdata = '0; xlr_mem_be = '0; xlr_mem_rd = '0; xlr_mem_wr = '0;
    host_mem_req = 1'b0; host_mem_wr = 1'b0; host_mem_sel = '0; host_mem_addr = '0;
    host_mem_wdata = '0; host_mem_be = '0;
  endtask

  // One clock: sample grant, advance the model by the current inputs, settle after the edge.
  task automatic cycle();
    logic oor;
    logic [255:0] old;
    @(negedge clk);
    oor = (int'(host_mem_sel) >= NM);
    obs_gnt = host_mem_gnt;
    if (oor) exp_gnt = host_mem_req;
    else exp_gnt = host_mem_req && !(xlr_mem_rd[host_mem_sel] || xlr_mem_wr[host_mem_sel]);
    if (rst) begin
      for (int i = 0; i < NM; i++) m_xrd[i] = '0;
      m_hrd = '0; m_rv = 1'b0; m_err = 1'b0; m_stall = '0;
    end else begin
      m_rv = 1'b0; m_err = 1'b0;
      if (host_mem_req && !exp_gnt && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (exp_gnt) begin
        if (oor) begin
          m_err = 1'b1;
          if (!host_mem_wr) begin m_hrd = '0; m_rv = 1'b1; end
        end else if (host_mem_wr)
          m_mem[host_mem_sel][host_mem_addr] =
            merge(m_mem[host_mem_sel][host_mem_addr], host_mem_wdata, host_mem_be);
        else begin
          m_hrd = m_mem[host_mem_sel][host_mem_addr]; m_rv = 1'b1;
        end
      end
      for (int i = 0; i < NM; i++) begin
        old = m_mem[i][xlr_mem_addr[i]];
        if (xlr_mem_rd[i])
          m_xrd[i] = (BYP && xlr_mem_wr[i]) ? merge(old, xlr_mem_wdata[i], xlr_mem_be[i]) : old;
        if (xlr_mem_wr[i]) m_mem[i][xlr_mem_addr[i]] = merge(old, xlr_mem_wdata[i], xlr_mem_be[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    cycle(); cycle();
    for (int i = 0; i < NM; i++) begin
      total++;
      if (xlr_mem_rdata[i] !== '0) begin
        bad++; $display("FAIL reset_xlr_rdata[%0d] got=%h exp=0", i, xlr_mem_rdata[i]);
      end
    end
    total++;
    if (host_mem_rdata !== '0 || host_mem_rvalid !== 1'b0 || host_mem_err !== 1'b0 ||
        host_stall_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_host got rd=%h rv=%b err=%b stall=%0d exp all 0",
                      host_mem_rdata, host_mem_rvalid, host_mem_err, host_stall_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_preload();
    idle();
    for (int i = 0; i < NM; i++)
      for (int a = 0; a < LINES; a++) begin
        host_mem_req = 1'b1; host_mem_wr = 1'b1; host_mem_sel = SW'(i); host_mem_addr = AW'(a);
        for (int w = 0; w < 8; w++) host_mem_wdata[w] = $urandom;
        host_mem_be = '1;
        cycle();
        total++;
        if (obs_gnt !== 1'b1) begin
          bad++; $display("FAIL preload_gnt inst%0d line%0d got=%b exp=1", i, a, obs_gnt);
        end
      end
    idle();
  endtask

  task automatic test_host_rw();
    xbox_line_t l;
    for (int w = 0; w < 8; w++) l[w] = 32'(w + 1);
    idle();
    host_mem_req = 1'b1; host_mem_wr = 1'b1; host_mem_be = '1; host_mem_wdata = l;
    cycle();
    host_mem_wr = 1'b0;
    cycle();
    total++;
    if (host_mem_rvalid !== 1'b1 || host_mem_rdata !== l) begin
      bad++; $display("FAIL host_rw got rv=%b rd=%h exp rv=1 rd=%h", host_mem_rvalid, host_mem_rdata, l);
    end
    idle(); cycle();
    total++;
    if (host_mem_rvalid !== 1'b0 || host_mem_rdata !== l) begin
      bad++; $display("FAIL host_rw_hold got rv=%b rd=%h exp rv=0 rd=%h", host_mem_rvalid, host_mem_rdata, l);
    end
  endtask

  task automatic test_xlr_read_hold();
    xbox_line_t l;
    for (int w = 0; w < 8; w++) l[w] = 32'(w + 1);
    idle(); xlr_mem_rd[0] = 1'b1; xlr_mem_addr[0] = '0;
    cycle();
    idle();
    for (int c = 0; c < 4; c++) begin
      total++;
      if (xlr_mem_rdata[0] !== l) begin
        bad++; $display("FAIL xlr_read_hold c%0d got=%h exp=%h", c, xlr_mem_rdata[0], l);
      end
      cycle();
    end
  endtask

  task automatic test_byte_write();
    xbox_line_t l;
    l = '0; l[0] = 32'hAAAAAAAA;
    idle();
    host_mem_req = 1'b1; host_mem_wr = 1'b1; host_mem_addr = 4'd1; host_mem_be = '1;
    cycle();
    idle();
    xlr_mem_wr[0] = 1'b1; xlr_mem_addr[0] = 4'd1; xlr_mem_wdata[0] = {8{32'hAAAAAAAA}};
    xlr_mem_be[0] = 32'h0000000F;
    cycle();
    idle(); xlr_mem_rd[0] = 1'b1; xlr_mem_addr[0] = 4'd1; xlr_mem_be[0] = 32'h12345678;
    cycle();
    total++;
    if (xlr_mem_rdata[0] !== l) begin
      bad++; $display("FAIL byte_write got=%h exp=%h", xlr_mem_rdata[0], l);
    end
    idle();
  endtask

  task automatic test_arbitration();
    idle();
    host_mem_req = 1'b1; host_mem_addr = 4'd3;
    xlr_mem_rd[0] = 1'b1; xlr_mem_addr[0] = 4'd5;
    for (int c = 0; c < 3; c++) begin
      cycle();
      total++;
      if (obs_gnt !== 1'b0) begin
        bad++; $display("FAIL arb_blocked c%0d got=%b exp=0", c, obs_gnt);
      end
    end
    total++;
    if (host_stall_cnt !== 16'd3 || xlr_mem_rdata[0] !== m_xrd[0]) begin
      bad++; $display("FAIL arb_stall got=%0d xrd=%h exp=3 xrd=%h", host_stall_cnt, xlr_mem_rdata[0], m_xrd[0]);
    end
    xlr_mem_rd[0] = 1'b0;
    cycle();
    total++;
    if (obs_gnt !== 1'b1 || host_mem_rvalid !== 1'b1 || host_mem_rdata !== m_mem[0][3]) begin
      bad++; $display("FAIL arb_grant got gnt=%b rv=%b rd=%h exp gnt=1 rv=1 rd=%h",
                      obs_gnt, host_mem_rvalid, host_mem_rdata, m_mem[0][3]);
    end
    idle();
  endtask

  task automatic test_rdw();
    xbox_line_t exp;
    exp = BYP ? {8{32'h5}} : '0;
    idle();
    host_mem_req = 1'b1; host_mem_wr = 1'b1; host_mem_addr = 4'd2; host_mem_be = '1;
    cycle();
    idle();
    xlr_mem_rd[0] = 1'b1; xlr_mem_wr[0] = 1'b1; xlr_mem_addr[0] = 4'd2;
    xlr_mem_wdata[0] = {8{32'h5}}; xlr_mem_be[0] = '1;
    cycle();
    total++;
    if (xlr_mem_rdata[0] !== exp) begin
      bad++; $display("FAIL rdw got=%h exp=%h", xlr_mem_rdata[0], exp);
    end
    idle(); xlr_mem_rd[0] = 1'b1; xlr_mem_addr[0] = 4'd2;
    cycle();
    total++;
    if (xlr_mem_rdata[0] !== {8{32'h5}}) begin
      bad++; $display("FAIL rdw_commit got=%h exp=all 5", xlr_mem_rdata[0]);
    end
    idle();
  endtask

  task automatic test_oor();
    idle();
    host_mem_req = 1'b1; host_mem_sel = 2'd3; host_mem_addr = 4'd1;
    xlr_mem_rd = '1; xlr_mem_wr = '0;
    cycle();
    total++;
    if (obs_gnt !== 1'b1 || host_mem_rvalid !== 1'b1 || host_mem_err !== 1'b1 || host_mem_rdata !== '0) begin
      bad++; $display("FAIL oor got gnt=%b rv=%b err=%b rd=%h exp 1 1 1 0",
                      obs_gnt, host_mem_rvalid, host_mem_err, host_mem_rdata);
    end
    idle(); cycle();
    total++;
    if (host_mem_rvalid !== 1'b0 || host_mem_err !== 1'b0) begin
      bad++; $display("FAIL oor_pulse got rv=%b err=%b exp 0 0", host_mem_rvalid, host_mem_err);
    end
  endtask

  task automatic test_random();
    idle();
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NM; i++) begin
        xlr_mem_rd[i] = ($urandom_range(0, 2) == 0);
        xlr_mem_wr[i] = ($urandom_range(0, 2) == 0);
        xlr_mem_addr[i] = AW'($urandom_range(0, LINES-1));
        for (int w = 0; w < 8; w++) xlr_mem_wdata[i][w] = $urandom;
        xlr_mem_be[i] = $urandom;
      end
      if (!host_mem_req && $urandom_range(0, 1) == 1) begin
        host_mem_req = 1'b1;
        host_mem_sel = SW'($urandom_range(0, 3));
        host_mem_wr = (int'(host_mem_sel) < NM) ? 1'($urandom_range(0, 1)) : 1'b0;
        host_mem_addr = AW'($urandom_range(0, LINES-1));
        for (int w = 0; w < 8; w++) host_mem_wdata[w] = $urandom;
        host_mem_be = $urandom;
      end
      cycle();
      total++;
      if (obs_gnt !== exp_gnt) begin
        bad++; $display("FAIL rnd_gnt n%0d got=%b exp=%b", n, obs_gnt, exp_gnt);
      end
      for (int i = 0; i < NM; i++) begin
        total++;
        if (xlr_mem_rdata[i] !== m_xrd[i]) begin
          bad++; $display("FAIL rnd_xlr_rdata[%0d] n%0d got=%h exp=%h", i, n, xlr_mem_rdata[i], m_xrd[i]);
        end
      end
      total++;
      if (host_mem_rdata !== m_hrd || host_mem_rvalid !== m_rv || host_mem_err !== m_err ||
          host_stall_cnt !== m_stall) begin
        bad++; $display("FAIL rnd_host n%0d got rd=%h rv=%b err=%b st=%0d exp rd=%h rv=%b err=%b st=%0d",
                        n, host_mem_rdata, host_mem_rvalid, host_mem_err, host_stall_cnt,
                        m_hrd, m_rv, m_err, m_stall);
      end
      if (host_mem_req && obs_gnt) host_mem_req = 1'b0;
    end
    idle();
  endtask

  task automatic test_saturation();
    idle();
    host_mem_req = 1'b1; xlr_mem_rd[0] = 1'b1;
    for (int c = 0; c < 65545; c++) cycle();
    total++;
    if (host_stall_cnt !== 16'hFFFF || obs_gnt !== 1'b0) begin
      bad++; $display("FAIL stall_sat got=%h gnt=%b exp=ffff gnt=0", host_stall_cnt, obs_gnt);
    end
    idle();
  endtask

  task automatic test_reset_midread();
    idle();
    xlr_mem_rd[0] = 1'b1; host_mem_req = 1'b1; host_mem_sel = 2'd1;
    cycle();
    rst = 1'b1;
    cycle();
    total++;
    if (xlr_mem_rdata[0] !== '0 || host_mem_rdata !== '0 || host_mem_rvalid !== 1'b0 ||
        host_mem_err !== 1'b0 || host_stall_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_midread got xrd=%h hrd=%h rv=%b err=%b st=%0d exp all 0",
                      xlr_mem_rdata[0], host_mem_rdata, host_mem_rvalid, host_mem_err, host_stall_cnt);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_preload();
    test_host_rw();
    test_xlr_read_hold();
    test_byte_write();
    test_arbitration();
    test_rdw();
    test_oor();
    test_random();
    test_saturation();
    test_reset_midread();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
